rx_ber_checker: RTL and testbench

- Receive-side stage fed directly by the polyphase shaping filter output (S(8,7) oversampled stream, OS samples per symbol).
- Decimates to one sample per symbol at a programmable phase and slices it to a bit (sign; 1 = negative, matching the filter's 1 -> -coeff mapping).
- Searches exhaustively for the latency between the transmitted reference bits and the decisions, locks on the best delay, then accumulates error and bit counts for BER measurement.

---
 rtl/rx_ber_checker_pkg.sv | 28 ++
 rtl/rx_downsampler_slicer.sv | 64 ++++++
 rtl/rx_ber_checker.sv | 158 +++++++++++++++
 tb/tb_rx_ber_checker.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_ber_checker_pkg.sv
// Shared types and width helpers for the receive-side BER checker.
// Default sizes match the production configuration.
package rx_ber_checker_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCK   = 1'b1
    } ber_state_e;

    localparam int NBT_DEF   = 8;
    localparam int OS_DEF    = 4;
    localparam int DEPTH_DEF = 511;
    localparam int WIN_DEF   = 511;
    localparam int NBC_DEF   = 64;

    function automatic int ph_w(input int os);
        return $clog2(os);
    endfunction

    function automatic int dly_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int win_w(input int win);
        return $clog2(win + 1);
    endfunction

endpackage

// File: rtl/rx_downsampler_slicer.sv
// Picks one sample per symbol at a programmable phase and slices its sign.
// The selected phase is sampled at the symbol strobe so a change never splits a symbol.
module rx_downsampler_slicer
    import rx_ber_checker_pkg::*;
#(
    parameter int NBT_IN = NBT_DEF,
    parameter int OS     = OS_DEF
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic signed [NBT_IN-1:0] i_os_data,
    input  logic                     i_sym_strobe,
    input  logic [$clog2(OS)-1:0]    i_phase_sel,
    output logic                     o_rx_bit,
    output logic                     o_rx_valid
);

    localparam int PH_W = ph_w(OS);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS - 1);

    logic [PH_W-1:0] ph_q;
    logic [PH_W-1:0] ph_d;
    logic [PH_W-1:0] sel_q;
    logic [PH_W-1:0] sel_d;
    logic [PH_W-1:0] cur_ph;
    logic            bit_q;
    logic            bit_d;
    logic            vld_q;
    logic            vld_d;

    // The strobe cycle is phase 0 regardless of where the free count sits.
    always_comb begin
        cur_ph = ph_q;
        sel_d  = sel_q;
        if (i_sym_strobe) begin
            cur_ph = '0;
            sel_d  = i_phase_sel;
        end
        ph_d  = (cur_ph == PH_LAST) ? '0 : cur_ph + 1'b1;
        vld_d = (cur_ph == sel_d);
        bit_d = bit_q;
        if (vld_d) begin
            bit_d = (i_os_data < 0);
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            ph_q  <= '0;
            sel_q <= '0;
            bit_q <= 1'b0;
            vld_q <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            sel_q <= sel_d;
            bit_q <= bit_d;
            vld_q <= vld_d;
        end
    end

    assign o_rx_bit   = bit_q;
    assign o_rx_valid = vld_q;

endmodule

// File: rtl/rx_ber_checker.sv
// Receive BER checker: finds the reference-to-decision latency by exhaustive
// windowed search, then locks and accumulates error and bit counts.
module rx_ber_checker
    import rx_ber_checker_pkg::*;
#(
    parameter int NBT_IN = NBT_DEF,
    parameter int OS     = OS_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int WIN    = WIN_DEF,
    parameter int NB_CNT = NBC_DEF
) (
    input  logic                     clk,
    input  logic                     i_reset,
    input  logic signed [NBT_IN-1:0] i_os_data,
    input  logic                     i_sym_strobe,
    input  logic                     i_ref_bit,
    input  logic [$clog2(OS)-1:0]    i_phase_sel,
    input  logic                     i_restart,
    output logic                     o_rx_bit,
    output logic                     o_rx_valid,
    output logic                     o_locked,
    output logic [$clog2(DEPTH)-1:0] o_delay,
    output logic [NB_CNT-1:0]        o_err_cnt,
    output logic [NB_CNT-1:0]        o_bit_cnt
);

    localparam int DLY_W = dly_w(DEPTH);
    localparam int WC_W  = win_w(WIN);
    localparam logic [DLY_W-1:0] CAND_LAST = DLY_W'(DEPTH - 1);
    localparam logic [WC_W-1:0]  WIN_LAST  = WC_W'(WIN - 1);

    ber_state_e        state_q;
    ber_state_e        state_d;
    logic [DEPTH-1:0]  ref_q;
    logic [DEPTH-1:0]  ref_d;
    logic [DLY_W-1:0]  cand_q;
    logic [DLY_W-1:0]  cand_d;
    logic [DLY_W-1:0]  best_q;
    logic [DLY_W-1:0]  best_d;
    logic [DLY_W-1:0]  sel_idx;
    logic [WC_W-1:0]   win_q;
    logic [WC_W-1:0]   win_d;
    logic [WC_W-1:0]   acc_q;
    logic [WC_W-1:0]   acc_d;
    logic [WC_W-1:0]   min_q;
    logic [WC_W-1:0]   min_d;
    logic [WC_W-1:0]   acc_sum;
    logic [NB_CNT-1:0] err_q;
    logic [NB_CNT-1:0] err_d;
    logic [NB_CNT-1:0] bits_q;
    logic [NB_CNT-1:0] bits_d;
    logic              rx_bit;
    logic              rx_valid;
    logic              err_bit;

    rx_downsampler_slicer #(
        .NBT_IN (NBT_IN),
        .OS     (OS)
    ) u_ds (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_os_data    (i_os_data),
        .i_sym_strobe (i_sym_strobe),
        .i_phase_sel  (i_phase_sel),
        .o_rx_bit     (rx_bit),
        .o_rx_valid   (rx_valid)
    );

    assign ref_d   = i_sym_strobe ? {ref_q[DEPTH-2:0], i_ref_bit} : ref_q;
    assign sel_idx = (state_q == LOCK) ? best_q : cand_q;
    assign err_bit = rx_bit ^ ref_q[sel_idx];
    assign acc_sum = acc_q + WC_W'(err_bit);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        best_d  = best_q;
        win_d   = win_q;
        acc_d   = acc_q;
        min_d   = min_q;
        err_d   = err_q;
        bits_d  = bits_q;
        if (i_restart) begin
            state_d = SEARCH;
            cand_d  = '0;
            best_d  = '0;
            win_d   = '0;
            acc_d   = '0;
            min_d   = '1;
            err_d   = '0;
            bits_d  = '0;
        end else if (rx_valid) begin
            unique case (state_q)
                SEARCH: begin
                    if (win_q == WIN_LAST) begin
                        win_d = '0;
                        acc_d = '0;
                        if (acc_sum < min_q) begin
                            min_d  = acc_sum;
                            best_d = cand_q;
                        end
                        // A clean window cannot be beaten, so stop searching.
                        if (acc_sum == '0 || cand_q == CAND_LAST) begin
                            state_d = LOCK;
                        end else begin
                            cand_d = cand_q + 1'b1;
                        end
                    end else begin
                        win_d = win_q + 1'b1;
                        acc_d = acc_sum;
                    end
                end
                LOCK: begin
                    // Errors never exceed bits, so freezing on bits covers both.
                    if (bits_q != '1) begin
                        bits_d = bits_q + 1'b1;
                        err_d  = err_q + NB_CNT'(err_bit);
                    end
                end
                default: begin
                    state_d = SEARCH;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= SEARCH;
            ref_q   <= '0;
            cand_q  <= '0;
            best_q  <= '0;
            win_q   <= '0;
            acc_q   <= '0;
            min_q   <= '1;
            err_q   <= '0;
            bits_q  <= '0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_d;
            cand_q  <= cand_d;
            best_q  <= best_d;
            win_q   <= win_d;
            acc_q   <= acc_d;
            min_q   <= min_d;
            err_q   <= err_d;
            bits_q  <= bits_d;
        end
    end

    assign o_rx_bit   = rx_bit;
    assign o_rx_valid = rx_valid;
    assign o_locked   = (state_q == LOCK);
    assign o_delay    = best_q;
    assign o_err_cnt  = err_q;
    assign o_bit_cnt  = bits_q;

endmodule

// File: tb/tb_rx_ber_checker.sv
// Directed/randomized bench for rx_ber_checker with a window-level search
// model computed from the recorded reference and decision histories.
module tb_rx_ber_checker;

    localparam int NBT_IN = 8;
    localparam int OS     = 4;
    localparam int DEPTH  = 16;
    localparam int WIN    = 32;
    localparam int NB_CNT = 64;

    logic              clk = 1'b0;
    logic              i_reset;
    logic signed [7:0] i_os_data;
    logic              i_sym_strobe;
    logic              i_ref_bit;
    logic [1:0]        i_phase_sel;
    logic              i_restart;
    logic              o_rx_bit;
    logic              o_rx_valid;
    logic              o_locked;
    logic [3:0]        o_delay;
    logic [63:0]       o_err_cnt;
    logic [63:0]       o_bit_cnt;

    always #5 clk = ~clk;

    rx_ber_checker #(
        .NBT_IN (NBT_IN),
        .OS     (OS),
        .DEPTH  (DEPTH),
        .WIN    (WIN),
        .NB_CNT (NB_CNT)
    ) dut (
        .clk          (clk),
        .i_reset      (i_reset),
        .i_os_data    (i_os_data),
        .i_sym_strobe (i_sym_strobe),
        .i_ref_bit    (i_ref_bit),
        .i_phase_sel  (i_phase_sel),
        .i_restart    (i_restart),
        .o_rx_bit     (o_rx_bit),
        .o_rx_valid   (o_rx_valid),
        .o_locked     (o_locked),
        .o_delay      (o_delay),
        .o_err_cnt    (o_err_cnt),
        .o_bit_cnt    (o_bit_cnt)
    );

    int errors = 0;
    int checks = 0;

    bit refs[$];
    bit decs[$];
    int dsy[$];
    int nsym = 0;
    int k0 = 0;

    bit     m_lk;
    int     m_dly;
    int     m_lkk;
    longint m_bits;
    longint m_errs;

    logic [8:0] prbs;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    function automatic bit refat(input int j);
        return (j < 0) ? 1'b0 : refs[j];
    endfunction

    function automatic bit prbs_next();
        bit nb;
        nb = prbs[8] ^ prbs[4];
        prbs = {prbs[7:0], nb};
        return nb;
    endfunction

    // Windows of WIN decisions, one candidate delay each, lowest delay wins ties.
    function automatic void model();
        int nd;
        int minv;
        int e;
        int k;
        nd = decs.size();
        minv = 1 << 30;
        m_lk = 1'b0;
        m_dly = 0;
        m_lkk = 0;
        m_bits = 0;
        m_errs = 0;
        for (int c = 0; c < DEPTH; c++) begin
            if (k0 + (c + 1) * WIN > nd) return;
            e = 0;
            for (int i = 0; i < WIN; i++) begin
                k = k0 + c * WIN + i;
                e += int'(decs[k] != refat(dsy[k] - c));
            end
            if (e < minv) begin
                minv = e;
                m_dly = c;
            end
            m_lkk = k0 + (c + 1) * WIN;
            if (e == 0) break;
        end
        m_lk = 1'b1;
        for (int kk = m_lkk; kk < nd; kk++) begin
            m_bits++;
            m_errs += longint'(decs[kk] != refat(dsy[kk] - m_dly));
        end
    endfunction

    task automatic chk(input string tag);
        model();
        check({tag, "_locked"}, o_locked, m_lk);
        if (m_lk) check({tag, "_delay"}, o_delay, 64'(m_dly));
        check({tag, "_bits"}, o_bit_cnt, 64'(m_bits));
        check({tag, "_errs"}, o_err_cnt, 64'(m_errs));
    endtask

    task automatic sym(input bit rb, input logic [7:0] s0, input logic [7:0] s1,
                       input logic [7:0] s2, input logic [7:0] s3,
                       input logic [1:0] sel, input bit rs);
        logic [7:0] s[4];
        s[0] = s0;
        s[1] = s1;
        s[2] = s2;
        s[3] = s3;
        if (rs) k0 = decs.size();
        refs.push_back(rb);
        for (int p = 0; p < OS; p++) begin
            i_sym_strobe = (p == 0);
            i_ref_bit = (p == 0) ? rb : 1'($urandom);
            i_restart = rs && (p == 0);
            i_os_data = s[p];
            if (p == 0) i_phase_sel = sel;
            @(posedge clk);
            #1;
            check("rx_valid", o_rx_valid, (p == int'(sel)));
            if (p == int'(sel)) begin
                decs.push_back(s[p][7]);
                dsy.push_back(nsym);
                check("rx_bit", o_rx_bit, s[p][7]);
            end
        end
        nsym++;
    endtask

    task automatic dtx(input bit rb, input bit db, input bit rs);
        logic [7:0] a;
        a = db ? 8'hC0 : 8'h40;
        sym(rb, 8'($urandom), 8'($urandom), a, 8'($urandom), 2'd2, rs);
    endtask

    task automatic reset_outs(input string tag);
        check({tag, "_locked"}, o_locked, 0);
        check({tag, "_delay"}, o_delay, 0);
        check({tag, "_errs"}, o_err_cnt, 0);
        check({tag, "_bits"}, o_bit_cnt, 0);
        check({tag, "_valid"}, o_rx_valid, 0);
        check({tag, "_rxbit"}, o_rx_bit, 0);
    endtask

    initial begin
        bit rb;
        bit tgt;
        bit fl;
        bit found;
        int c;
        int j;

        i_reset = 1'b1;
        i_os_data = '0;
        i_sym_strobe = 1'b0;
        i_ref_bit = 1'b0;
        i_phase_sel = 2'd2;
        i_restart = 1'b0;
        prbs = 9'($urandom_range(1, 511));
        repeat (3) @(posedge clk);
        #1;
        reset_outs("reset");
        i_reset = 1'b0;

        // Phase selection: only phase 3 is positive.
        repeat (20) sym(1'($urandom), 8'h9C, 8'h9C, 8'h9C, 8'h64, 2'd3, 1'b0);
        repeat (20) sym(1'($urandom), 8'h9C, 8'h9C, 8'h9C, 8'h64, 2'd0, 1'b0);

        // Every window has an error; delays 7 and 9 tie at one.
        for (int i = 0; i < DEPTH * WIN; i++) begin
            c = i / WIN;
            j = i % WIN;
            rb = 1'($urandom);
            tgt = (c == 0) ? rb : refat(nsym - c);
            fl = (j == 3) || (j == 10 && c != 7 && c != 9);
            dtx(rb, tgt ^ fl, i == 0);
            chk("nomatch");
        end
        check("nomatch_lock", o_locked, 1);
        check("nomatch_best", o_delay, 7);

        // PRBS9 loopback delayed by five symbols.
        found = 1'b0;
        for (int i = 0; i < DEPTH * WIN + WIN && !found; i++) begin
            rb = prbs_next();
            dtx(rb, refat(nsym - 5), i == 0);
            chk("loop_search");
            found = m_lk;
        end
        check("loop_delay", o_delay, 5);
        repeat (1000) begin
            rb = prbs_next();
            dtx(rb, refat(nsym - 5), 1'b0);
            chk("loop_lock");
        end
        check("loop_bits", o_bit_cnt, 1000);
        check("loop_errs", o_err_cnt, 0);

        // Restart from LOCK, relock, then inject every tenth error.
        rb = prbs_next();
        dtx(rb, refat(nsym - 5), 1'b1);
        check("restart_locked", o_locked, 0);
        check("restart_delay", o_delay, 0);
        check("restart_bits", o_bit_cnt, 0);
        check("restart_errs", o_err_cnt, 0);
        found = 1'b0;
        for (int i = 0; i < DEPTH * WIN + WIN && !found; i++) begin
            rb = prbs_next();
            dtx(rb, refat(nsym - 5), 1'b0);
            chk("relock");
            found = m_lk;
        end
        check("relock_delay", o_delay, 5);
        for (int i = 0; i < 1000; i++) begin
            rb = prbs_next();
            dtx(rb, refat(nsym - 5) ^ (i % 10 == 9), 1'b0);
            chk("inject");
        end
        check("inject_bits", o_bit_cnt, 1000);
        check("inject_errs", o_err_cnt, 100);

        // Asynchronous reset between clock edges.
        #2;
        i_reset = 1'b1;
        #1;
        reset_outs("async_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
